hamming_secded_dec: RTL and testbench

- Hardware Hamming SECDED decoder engine; the receive-side counterpart of the program-1 parity encoder.
- On a start pulse it walks data memory and reads NUM_WORDS 16-bit codewords, stored little-endian at byte SRC_BASE upward.
- For each codeword it corrects a single-bit error or flags a double error, then writes the 11-bit payload as a 16-bit word at DST_BASE upward.
- Sits beside TopLevel on the shared byte-wide data-memory port; start/done form the same handshake the program benches drive.

---
 rtl/hamming_pkg.sv | 42 ++++
 rtl/hamming_secded_dec_if.sv | 24 ++
 rtl/hamming_secded_core.sv | 34 +++
 rtl/hamming_secded_dec.sv | 153 +++++++++++++++
 tb/tb_hamming_secded_dec.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SECDED decoder: bit positions, FSM states
// and the codeword field helpers.
package hamming_pkg;

  localparam int P16 = 0;
  localparam int P1  = 1;
  localparam int P2  = 2;
  localparam int P4  = 4;
  localparam int P8  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_CAP   = 3'd3,
    S_DEC   = 3'd4,
    S_WR_LO = 3'd5,
    S_WR_HI = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

  // XOR of the Hamming positions of all set bits; bit 0 (P16) is not a position.
  function automatic logic [3:0] syndrome(input logic [15:0] cw);
    logic [3:0] syn;
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) begin
        syn = syn ^ 4'(k);
      end
    end
    return syn;
  endfunction

  function automatic logic overall_parity(input logic [15:0] cw);
    return ^cw;
  endfunction

endpackage

// File: rtl/hamming_secded_dec_if.sv
// Start/done handshake plus the byte-wide data-memory port and error counters.
interface hamming_secded_dec_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 5
);
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [CNT_W-1:0]  single_cnt;
  logic [CNT_W-1:0]  double_cnt;

  modport master (
    input  start, mem_rd_data,
    output done, mem_addr, mem_wr_en, mem_wr_data, single_cnt, double_cnt
  );

  modport slave (
    output start, mem_rd_data,
    input  done, mem_addr, mem_wr_en, mem_wr_data, single_cnt, double_cnt
  );
endinterface

// File: rtl/hamming_secded_core.sv
// Combinational SECDED decode of one 16-bit codeword into a 16-bit result word.
module hamming_secded_core
  import hamming_pkg::*;
(
  input  logic [15:0] codeword,
  output logic [15:0] result,
  output logic        single_err,
  output logic        double_err
);

  logic [3:0]  w_syn;
  logic        w_par;
  logic [15:0] w_fixed;

  // Classify the codeword and build the result; syndrome 0 with bad parity means p16 flipped.
  always_comb begin
    w_syn      = syndrome(codeword);
    w_par      = overall_parity(codeword);
    w_fixed    = codeword ^ (16'h0001 << w_syn);
    single_err = 1'b0;
    double_err = 1'b0;
    result     = 16'h0000;
    if (w_par) begin
      single_err = 1'b1;
      result     = {5'b00000, extract_data(w_fixed)};
    end else if (w_syn != 4'd0) begin
      double_err = 1'b1;
      result     = {1'b1, 4'b0000, extract_data(codeword)};
    end else begin
      result     = {5'b00000, extract_data(codeword)};
    end
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Memory-walking SECDED decoder: reads NUM_WORDS codewords, writes decoded
// payloads, counts corrected and double-error words.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 94,
  parameter int NUM_WORDS = 15,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 5
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  hamming_secded_dec_if.master bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  w_idx_nxt;
  logic              w_clear;
  logic [15:0]       r_code;
  logic [15:0]       r_result;
  logic [CNT_W-1:0]  r_single;
  logic [CNT_W-1:0]  r_double;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic [7:0]        r_wr_data;
  logic              r_done;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_wr_en_nxt;
  logic [7:0]        w_wr_data_nxt;
  logic              w_done_nxt;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;
  logic [15:0]       w_core_result;
  logic              w_single_err;
  logic              w_double_err;

  hamming_secded_core u_core (
    .codeword   (r_code),
    .result     (w_core_result),
    .single_err (w_single_err),
    .double_err (w_double_err)
  );

  // Next-state and word-index sequencing; start is only honoured from IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_RD_LO;
          w_idx_nxt   = {CNT_W{1'b0}};
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RD_LO: w_state_nxt = S_RD_HI;
      S_RD_HI: w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_DEC;
      S_DEC:   w_state_nxt = S_WR_LO;
      S_WR_LO: w_state_nxt = S_WR_HI;
      S_WR_HI: begin
        if (r_idx == CNT_W'(NUM_WORDS - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_LO;
          w_idx_nxt   = r_idx + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Memory-port values for the state being entered, so the port is registered yet state-aligned.
  always_comb begin
    w_src_addr    = ADDR_W'(SRC_BASE) + ADDR_W'({w_idx_nxt, 1'b0});
    w_dst_addr    = ADDR_W'(DST_BASE) + ADDR_W'({w_idx_nxt, 1'b0});
    w_addr_nxt    = {ADDR_W{1'b0}};
    w_wr_en_nxt   = 1'b0;
    w_wr_data_nxt = 8'h00;
    w_done_nxt    = 1'b0;
    case (w_state_nxt)
      S_RD_LO: w_addr_nxt = w_src_addr;
      S_RD_HI: w_addr_nxt = w_src_addr + ADDR_W'(1);
      S_WR_LO: begin
        w_addr_nxt    = w_dst_addr;
        w_wr_en_nxt   = 1'b1;
        w_wr_data_nxt = w_core_result[7:0];
      end
      S_WR_HI: begin
        w_addr_nxt    = w_dst_addr + ADDR_W'(1);
        w_wr_en_nxt   = 1'b1;
        w_wr_data_nxt = r_result[15:8];
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: w_addr_nxt = {ADDR_W{1'b0}};
    endcase
  end

  // State, datapath capture, counters and registered memory-port outputs.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_idx     <= {CNT_W{1'b0}};
      r_code    <= 16'h0000;
      r_result  <= 16'h0000;
      r_single  <= {CNT_W{1'b0}};
      r_double  <= {CNT_W{1'b0}};
      r_addr    <= {ADDR_W{1'b0}};
      r_wr_en   <= 1'b0;
      r_wr_data <= 8'h00;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_done    <= w_done_nxt;
      if (r_state == S_RD_HI) begin
        r_code[7:0] <= bus.mem_rd_data;
      end
      if (r_state == S_CAP) begin
        r_code[15:8] <= bus.mem_rd_data;
      end
      if (w_clear) begin
        r_single <= {CNT_W{1'b0}};
        r_double <= {CNT_W{1'b0}};
      end else if (r_state == S_DEC) begin
        r_result <= w_core_result;
        if (w_single_err) begin
          r_single <= r_single + CNT_W'(1);
        end
        if (w_double_err) begin
          r_double <= r_double + CNT_W'(1);
        end
      end
    end
  end

  assign bus.done        = r_done;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_wr_data = r_wr_data;
  assign bus.single_cnt  = r_single;
  assign bus.double_cnt  = r_double;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Randomized self-checking bench for hamming_secded_dec with an encode/inject
// reference model and a byte-wide synchronous memory.
module tb_hamming_secded_dec;

  localparam int SRC = 64;
  localparam int DST = 94;
  localparam int NW  = 15;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hamming_secded_dec_if #(.ADDR_W(8), .CNT_W(5)) bus ();

  hamming_secded_dec #(
    .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW), .ADDR_W(8), .CNT_W(5)
  ) dut (
    .CLK     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0]  src_img [0:2*NW-1];
  logic [7:0]  dst_mem [0:255];
  logic [15:0] cw_img  [NW];
  logic [15:0] exp_res [NW];
  int          exp_single;
  int          exp_double;
  int          n_checks = 0;
  int          n_errors = 0;
  int          dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  // Synchronous-read memory: source image is read-only, destination collects writes.
  always @(posedge clk) begin
    if (bus.mem_addr >= 8'(SRC) && bus.mem_addr < 8'(SRC + 2*NW))
      bus.mem_rd_data <= src_img[bus.mem_addr - 8'(SRC)];
    else
      bus.mem_rd_data <= 8'h00;
    if (bus.mem_wr_en)
      dst_mem[bus.mem_addr] <= bus.mem_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    logic [3:0]  s;
    cw = 16'h0000;
    s  = 4'h0;
    for (int j = 0; j < 11; j++) cw[dpos[j]] = d[j];
    for (int k = 1; k < 16; k++) if (cw[k]) s = s ^ 4'(k);
    cw[1] = s[0]; cw[2] = s[1]; cw[4] = s[2]; cw[8] = s[3];
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    for (int j = 0; j < 11; j++) d[j] = cw[dpos[j]];
    return d;
  endfunction

  task automatic load_words();
    for (int w = 0; w < NW; w++) begin
      src_img[2*w]   = cw_img[w][7:0];
      src_img[2*w+1] = cw_img[w][15:8];
    end
  endtask

  // Random payloads, each clean, single-flipped or double-flipped; outcome follows from the injection.
  task automatic gen_random();
    exp_single = 0;
    exp_double = 0;
    for (int w = 0; w < NW; w++) begin
      logic [10:0] d;
      logic [15:0] cw;
      int kind, a, b;
      d    = 11'($urandom_range(0, 2047));
      cw   = encode(d);
      kind = (w < 2) ? w + 1 : int'($urandom_range(0, 2));
      if (kind == 1) begin
        a  = $urandom_range(0, 15);
        cw = cw ^ (16'h0001 << a);
        exp_res[w] = {5'b00000, d};
        exp_single++;
      end else if (kind == 2) begin
        a  = $urandom_range(0, 15);
        b  = (a + int'($urandom_range(1, 15))) % 16;
        cw = cw ^ (16'h0001 << a) ^ (16'h0001 << b);
        exp_res[w] = {1'b1, 4'b0000, extract(cw)};
        exp_double++;
      end else begin
        exp_res[w] = {5'b00000, d};
      end
      cw_img[w] = cw;
    end
    load_words();
  endtask

  // One run: pulse start, check every write as it happens, then timing, counters and memory.
  task automatic run(input int glitch_at, input int abort_at);
    int wr_seen;
    int done_at;
    int off;
    logic [7:0] eb;
    wr_seen = 0;
    done_at = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_done_low", 32'(bus.done), 32'd0);
    check("start_single_clr", 32'(bus.single_cnt), 32'd0);
    check("start_double_clr", 32'(bus.double_cnt), 32'd0);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("abort_single", 32'(bus.single_cnt), 32'd0);
        check("abort_double", 32'(bus.double_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (bus.mem_wr_en) begin
        wr_seen++;
        off = int'(bus.mem_addr) - DST;
        check("wr_in_range", 32'(off >= 0 && off < 2*NW), 32'd1);
        if (off >= 0 && off < 2*NW) begin
          eb = off[0] ? exp_res[off/2][15:8] : exp_res[off/2][7:0];
          check("wr_data", 32'(bus.mem_wr_data), 32'(eb));
        end
      end
      if (c == glitch_at) bus.start = 1'b1;
      else if (c == glitch_at + 1) bus.start = 1'b0;
      if (bus.done) begin
        done_at = c;
        break;
      end
    end
    bus.start = 1'b0;
    check("done_cycle", 32'(done_at), 32'd90);
    check("wr_count", 32'(wr_seen), 32'(2*NW));
    check("single_cnt", 32'(bus.single_cnt), 32'(exp_single));
    check("double_cnt", 32'(bus.double_cnt), 32'(exp_double));
    for (int w = 0; w < NW; w++)
      check("mem_result", 32'({dst_mem[DST+2*w+1], dst_mem[DST+2*w]}), 32'(exp_res[w]));
    repeat (3) @(posedge clk);
    #1;
    check("done_held", 32'(bus.done), 32'd1);
    check("idle_wr_en", 32'(bus.mem_wr_en), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    #12;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    check("rst_single", 32'(bus.single_cnt), 32'd0);
    check("rst_double", 32'(bus.double_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    check("model_enc_zero", 32'(encode(11'h000)), 32'h0000);
    check("model_enc_ones", 32'(encode(11'h7FF)), 32'hFFFF);
    check("model_enc_d1", 32'(encode(11'h001)), 32'h000F);
    check("model_extract", 32'(extract(16'h0208)), 32'h011);

    // Directed words with literal expectations.
    for (int w = 0; w < NW; w++) begin
      cw_img[w]  = 16'h0000;
      exp_res[w] = 16'h0000;
    end
    cw_img[1] = 16'hFFFF; exp_res[1] = 16'h07FF;
    cw_img[2] = 16'h0040;
    cw_img[3] = 16'h0001;
    cw_img[4] = 16'h0208; exp_res[4] = 16'h8011;
    exp_single = 2;
    exp_double = 1;
    load_words();
    run(0, 0);

    gen_random();
    run(20, 0);
    run(0, 0);

    gen_random();
    run(0, 32);
    run(0, 0);

    gen_random();
    run(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
